// File: rtl/capture_seq_pkg.sv
// Shared state encoding and default sizing for the capture sequencer.
package capture_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_ARM       = 3'd2,
        ST_RUN       = 3'd3,
        ST_GAP       = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERR       = 3'd6
    } cap_state_e;

    localparam int DEF_FRAME_CNT_W   = 16;
    localparam int DEF_LOCK_WAIT     = 1024;
    localparam int DEF_GAP_CYCLES    = 64;
    localparam int DEF_FRAME_TIMEOUT = 1 << 24;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/capture_sequencer.sv
// Frame-capture controller: lock wait, one capture per frame, EOF tracking, inter-frame gap.
// Optional frame watchdog is built when CAPTURE_SEQ_WATCHDOG_EN is defined.
module capture_sequencer
    import capture_seq_pkg::*;
#(
    parameter int FRAME_CNT_W = DEF_FRAME_CNT_W,
    parameter int LOCK_WAIT   = DEF_LOCK_WAIT,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
`ifdef CAPTURE_SEQ_WATCHDOG_EN
    ,
    parameter int FRAME_TIMEOUT = DEF_FRAME_TIMEOUT
`endif
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [FRAME_CNT_W-1:0] num_frames,
    input  logic                   serde_locked,
    input  logic                   eof,
    output logic                   capture,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_idx,
    output logic                   done,
    output logic                   err_lock,
    output logic                   err_timeout,
    output logic [2:0]             state_dbg
);

    localparam int WAIT_W = $clog2(LOCK_WAIT + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    cap_state_e             r_state;
    cap_state_e             w_state_nxt;
    logic [FRAME_CNT_W-1:0] r_frames_tgt;
    logic [FRAME_CNT_W-1:0] r_frame_idx;
    logic [FRAME_CNT_W-1:0] w_idx_inc;
    logic                   r_err_lock;
    logic                   r_stop_pend;
    logic [WAIT_W-1:0]      r_wait_cnt;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic                   w_lock;
    logic                   w_accept;
    logic                   w_count;
    logic                   w_lock_err;
    logic                   w_to_err;
    logic                   w_wd_expire;

    sync_2ff u_lock_sync (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_d     (serde_locked),
        .o_q     (w_lock)
    );

    assign w_idx_inc = r_frame_idx + FRAME_CNT_W'(1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lock loss outranks EOF in RUN so an interrupted frame is never counted.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_count     = 1'b0;
        w_lock_err  = 1'b0;
        w_to_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_lock) begin
                    w_state_nxt = ST_ARM;
                end else if (r_wait_cnt == WAIT_W'(LOCK_WAIT - 1)) begin
                    w_lock_err  = 1'b1;
                    w_state_nxt = ST_ERR;
                end else if (stop) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_ARM: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!w_lock) begin
                    w_lock_err  = 1'b1;
                    w_state_nxt = ST_ERR;
                end else if (eof) begin
                    w_count = 1'b1;
                    if ((r_frames_tgt != '0) && (w_idx_inc == r_frames_tgt)) begin
                        w_state_nxt = ST_DONE;
                    end else if (r_stop_pend || stop) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_GAP;
                    end
                end else if (w_wd_expire) begin
                    w_to_err    = 1'b1;
                    w_state_nxt = ST_ERR;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    w_state_nxt = ST_DONE;
                end else if (r_gap_cnt == GAP_W'(GAP_CYCLES)) begin
                    w_state_nxt = w_lock ? ST_ARM : ST_WAIT_LOCK;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Per-state counters idle at zero, so each entry starts a fresh count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wait_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_wait_cnt <= (r_state == ST_WAIT_LOCK) ? r_wait_cnt + WAIT_W'(1) : '0;
            r_gap_cnt  <= (r_state == ST_GAP) ? r_gap_cnt + GAP_W'(1) : '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frames_tgt <= '0;
            r_frame_idx  <= '0;
            r_err_lock   <= 1'b0;
            r_stop_pend  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_frames_tgt <= num_frames;
                r_frame_idx  <= '0;
                r_err_lock   <= 1'b0;
            end else begin
                if (w_count) begin
                    r_frame_idx <= w_idx_inc;
                end
                if (w_lock_err) begin
                    r_err_lock <= 1'b1;
                end
            end
            if (w_state_nxt == ST_IDLE) begin
                r_stop_pend <= 1'b0;
            end else if (stop && ((r_state == ST_ARM) || (r_state == ST_RUN))) begin
                r_stop_pend <= 1'b1;
            end
        end
    end

`ifdef CAPTURE_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(FRAME_TIMEOUT + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err_timeout;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_wd_cnt <= ((r_state == ST_RUN) && !eof) ? r_wd_cnt + WD_W'(1) : '0;
            if (w_accept) begin
                r_err_timeout <= 1'b0;
            end else if (w_to_err) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign w_wd_expire = (r_wd_cnt == WD_W'(FRAME_TIMEOUT - 1));
    assign err_timeout = r_err_timeout;
`else
    assign w_wd_expire = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign capture   = (r_state == ST_ARM);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign frame_idx = r_frame_idx;
    assign err_lock  = r_err_lock;
    assign state_dbg = r_state;

endmodule
